// File: rtl/multicycle_data_path.sv
// multicycle_data_path
//   Multi-cycle MIPS-subset datapath. One shared instruction/data memory
//   port with a valid/ack handshake; internal IR/A/B/ALUOut/MDR registers,
//   sequenced by a FETCH/DECODE/EXEC/MEM/WB state machine. The register
//   file, ALU and sign extension live inside this file.
//
//   Build option: define MCDP_BNE_EN to decode BNE (op 0x05). Without it,
//   op 0x05 is illegal and traps into HALT.
//
// Parameters
//   RESET_PC   byte address loaded into pc on reset
//   ADDR_W     memory word-address width (mem_addr = byte_addr[ADDR_W+1:2])
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mem_req    memory request valid (FETCH or MEM, once running)
//   mem_we     write strobe, valid with mem_req
//   mem_addr   word address
//   mem_wdata  store data (B register)
//   mem_rdata  read data, sampled in the ack cycle
//   mem_ack    completes the current request
//   pc         current program counter (byte address)
//   retire     one-cycle pulse on the final cycle of each instruction
//   halted     sticky, set by the illegal-opcode trap

module multicycle_data_path #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       pc,
    output logic              retire,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_XOR = 2'd2;
    localparam logic [1:0] ALU_SLT = 2'd3;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'd0, v};
    endfunction

    function automatic logic [31:0] alu_fn(input logic [1:0]  ctrl,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (ctrl)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_XOR: return a ^ b;
            default: return (sa < sb) ? 32'd1 : 32'd0;
        endcase
    endfunction

    state_t      state, state_nx;
    logic        run;
    logic [31:0] ir;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [31:0] alu_out;
    logic [31:0] mdr;

    logic [31:0] rf [0:31];
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] rd_a;
    logic [31:0] rd_b;

    // Instruction fields
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign imm16 = ir[15:0];

    logic is_rtype, is_add, is_sub, is_slt, is_jr, is_alu_r;
    logic is_lw, is_sw, is_addi, is_xori, is_beq, is_j, is_jal;
    logic is_branch, branch_taken, legal;

    assign is_rtype = (op == 6'h00);
    assign is_add   = is_rtype && (funct == 6'h20);
    assign is_sub   = is_rtype && (funct == 6'h22);
    assign is_slt   = is_rtype && (funct == 6'h2a);
    assign is_jr    = is_rtype && (funct == 6'h08);
    assign is_alu_r = is_add || is_sub || is_slt;
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2b);
    assign is_addi  = (op == 6'h08);
    assign is_xori  = (op == 6'h0e);
    assign is_beq   = (op == 6'h04);
    assign is_j     = (op == 6'h02);
    assign is_jal   = (op == 6'h03);

    // ALU operand/control selection, used in EXEC
    logic [1:0]  alu_ctrl;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_zero;

`ifdef MCDP_BNE_EN
    logic is_bne;
    assign is_bne       = (op == 6'h05);
    assign is_branch    = is_beq || is_bne;
    assign branch_taken = (is_beq && alu_zero) || (is_bne && !alu_zero);
`else
    assign is_branch    = is_beq;
    assign branch_taken = is_beq && alu_zero;
`endif

    assign legal = is_alu_r || is_jr || is_lw || is_sw || is_addi ||
                   is_xori || is_branch || is_j || is_jal;

    always_comb begin
        alu_ctrl = ALU_ADD;
        if (is_sub || is_branch) begin
            alu_ctrl = ALU_SUB;
        end else if (is_xori) begin
            alu_ctrl = ALU_XOR;
        end else if (is_slt) begin
            alu_ctrl = ALU_SLT;
        end
    end

    assign alu_b    = (is_rtype || is_branch) ? reg_b :
                      is_xori                 ? zext16(imm16) : sext16(imm16);
    assign alu_res  = alu_fn(alu_ctrl, reg_a, alu_b);
    assign alu_zero = (alu_res == 32'd0);

    // Register file: r0 reads as zero; writes to r0 are blocked upstream
    assign rd_a = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rd_b = (rt == 5'd0) ? 32'd0 : rf[rt];

    always_ff @(posedge clk) begin
        if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // Memory port. Everything here derives from registers only, so the
    // request is stable until the ack edge and drops asynchronously on reset.
    assign mem_req   = run && ((state == S_FETCH) || (state == S_MEM));
    assign mem_we    = mem_req && (state == S_MEM) && is_sw;
    assign mem_addr  = (state == S_MEM) ? alu_out[ADDR_W+1:2] : pc[ADDR_W+1:2];
    assign mem_wdata = reg_b;
    assign halted    = (state == S_HALT);

    // Next state, retire and register-file write
    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_out;
        case (state)
            S_FETCH: begin
                if (mem_req && mem_ack) begin
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    state_nx = S_HALT;
                end else if (is_j || is_jr) begin
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end else if (is_jal) begin
                    // pc already holds the address after the jump: that is the link
                    retire   = 1'b1;
                    rf_we    = 1'b1;
                    rf_waddr = 5'd31;
                    rf_wdata = pc;
                    state_nx = S_FETCH;
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                if (mem_req && mem_ack) begin
                    if (is_sw) begin
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                retire   = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = is_rtype ? rd : rt;
                rf_wdata = is_lw ? mdr : alu_out;
                state_nx = S_FETCH;
            end
            S_HALT: begin
                state_nx = S_HALT;
            end
            default: begin
                state_nx = S_FETCH;
            end
        endcase
        if (rf_waddr == 5'd0) begin
            rf_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            run     <= 1'b0;
            pc      <= RESET_PC;
            ir      <= 32'd0;
            reg_a   <= 32'd0;
            reg_b   <= 32'd0;
            alu_out <= 32'd0;
            mdr     <= 32'd0;
        end else begin
            run   <= 1'b1;
            state <= state_nx;
            case (state)
                // FETCH -> DECODE
                S_FETCH: begin
                    if (mem_req && mem_ack) begin
                        ir <= mem_rdata;
                        pc <= pc + 32'd4;
                    end
                end
                // DECODE -> EXEC; branch target is precomputed into ALUOut
                S_DECODE: begin
                    reg_a   <= rd_a;
                    reg_b   <= rd_b;
                    alu_out <= pc + (sext16(imm16) << 2);
                    if (is_j || is_jal) begin
                        pc <= {pc[31:28], ir[25:0], 2'b00};
                    end else if (is_jr) begin
                        pc <= rd_a;
                    end
                end
                // EXEC -> MEM/WB
                S_EXEC: begin
                    if (is_branch) begin
                        if (branch_taken) begin
                            pc <= alu_out;
                        end
                    end else begin
                        alu_out <= alu_res;
                    end
                end
                // MEM -> WB
                S_MEM: begin
                    if (mem_req && mem_ack && is_lw) begin
                        mdr <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_data_path.sv
// Directed bench for multicycle_data_path: a memory responder with a
// configurable ack delay on data addresses, and a program whose results
// are stored back to memory so register contents become observable.

module tb_multicycle_data_path;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] pc;
    logic        retire;
    logic        halted;

    logic [31:0] mem [0:4095];
    int          data_delay;
    int          wait_cnt;
    int          hold_cnt;
    int          last_hold;
    int          checks;
    int          errors;

    multicycle_data_path #(
        .RESET_PC(32'h0000_0100),
        .ADDR_W  (12)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .pc       (pc),
        .retire   (retire),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [31:0] byte_addr, input logic [31:0] word);
        mem[byte_addr[13:2]] = word;
    endtask

    // Runs from the first cycle of an instruction to its retire cycle, checks
    // the cycle count, then steps one cycle and checks the next pc.
    task automatic run_instr(input string tag, input int exp_cpi, input logic [31:0] exp_pc);
        int cyc;
        cyc = 1;
        while (!retire && cyc < 64) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_val({tag, "_retire"}, 32'(retire), 32'd1);
        check_val({tag, "_cpi"}, 32'(cyc), 32'(exp_cpi));
        @(negedge clk);
        #1;
        check_val({tag, "_pc"}, pc, exp_pc);
    endtask

    // Memory responder: words below 16 are data and get data_delay waits
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        wait_cnt  = 0;
        hold_cnt  = 0;
        last_hold = 0;
        forever begin
            @(negedge clk);
            if (!mem_req) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
                hold_cnt = 0;
            end else begin
                if (mem_we) hold_cnt++;
                if (mem_addr < 12'd16 && wait_cnt < data_delay) begin
                    mem_ack = 1'b0;
                    wait_cnt++;
                end else begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        last_hold     = hold_cnt;
                        hold_cnt      = 0;
                    end else begin
                        mem_rdata = mem[mem_addr];
                    end
                end
            end
        end
    end

    initial begin
        int bad;
        int n;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        data_delay = 3;
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        for (int i = 2; i < 8; i++) mem[i] = 32'hDEAD_BEEF;
        put(32'h100, 32'h2001_0005); // ADDI r1,r0,5
        put(32'h104, 32'h2002_FFFD); // ADDI r2,r0,-3
        put(32'h108, 32'h0022_1822); // SUB  r3,r1,r2
        put(32'h10C, 32'h0041_202A); // SLT  r4,r2,r1
        put(32'h110, 32'h3825_FFFF); // XORI r5,r1,0xFFFF
        put(32'h114, 32'hAC03_0008); // SW   r3,8(r0)
        put(32'h118, 32'h8C06_0008); // LW   r6,8(r0)
        put(32'h11C, 32'hAC04_000C); // SW   r4,12(r0)
        put(32'h120, 32'hAC05_0010); // SW   r5,16(r0)
        put(32'h124, 32'hAC06_0014); // SW   r6,20(r0)
        put(32'h128, 32'h2000_0007); // ADDI r0,r0,7
        put(32'h12C, 32'hAC00_0018); // SW   r0,24(r0)
        put(32'h130, 32'h1022_0005); // BEQ  r1,r2,+5 (not taken)
        put(32'h134, 32'h0800_0080); // J    0x200
        put(32'h200, 32'h0C00_00C0); // JAL  0x300
        put(32'h204, 32'h1422_0002); // BNE  r1,r2,+2
        put(32'h210, 32'h1021_FFFF); // BEQ  r1,r1,-1 (self loop)
        put(32'h300, 32'hAC1F_001C); // SW   r31,28(r0)
        put(32'h304, 32'h03E0_0008); // JR   r31

        repeat (3) @(negedge clk);
        #1;
        check_val("rst_req", 32'(mem_req), 32'd0);
        check_val("rst_retire", 32'(retire), 32'd0);
        check_val("rst_halted", 32'(halted), 32'd0);
        check_val("rst_pc", pc, 32'h100);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("req_before_run", 32'(mem_req), 32'd0);
        @(negedge clk);
        #1;
        check_val("first_req", 32'(mem_req), 32'd1);
        check_val("first_addr", 32'(mem_addr), 32'h40);
        check_val("first_pc", pc, 32'h100);

        run_instr("addi_r1", 4, 32'h104);
        run_instr("addi_r2", 4, 32'h108);
        run_instr("sub_r3", 4, 32'h10C);
        run_instr("slt_r4", 4, 32'h110);
        run_instr("xori_r5", 4, 32'h114);
        run_instr("sw_r3", 7, 32'h118);
        check_val("sw_r3_hold", 32'(last_hold), 32'd4);
        check_val("sw_r3_data", mem[2], 32'd8);
        run_instr("lw_r6", 8, 32'h11C);
        run_instr("sw_r4", 7, 32'h120);
        check_val("r4_slt", mem[3], 32'd1);
        run_instr("sw_r5", 7, 32'h124);
        check_val("r5_xori", mem[4], 32'h0000_FFFA);
        run_instr("sw_r6", 7, 32'h128);
        check_val("r6_lw", mem[5], 32'd8);
        run_instr("addi_r0", 4, 32'h12C);
        run_instr("sw_r0", 7, 32'h130);
        check_val("r0_zero", mem[6], 32'd0);
        run_instr("beq_nt", 3, 32'h134);
        run_instr("j", 2, 32'h200);
        run_instr("jal", 2, 32'h300);
        run_instr("sw_r31", 7, 32'h304);
        check_val("r31_link", mem[7], 32'h204);
        run_instr("jr", 2, 32'h204);

`ifdef MCDP_BNE_EN
        run_instr("bne_taken", 3, 32'h210);
        run_instr("beq_loop1", 3, 32'h210);
        run_instr("beq_loop2", 3, 32'h210);
`else
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        check_val("bne_halted", 32'(halted), 32'd1);
        check_val("bne_halt_req", 32'(mem_req), 32'd0);
        check_val("bne_halt_pc", pc, 32'h208);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (mem_req || retire || !halted) bad++;
        end
        check_val("bne_halt_stays", 32'(bad), 32'd0);
`endif

        // Reset asserted while a store waits for ack
        rst_n = 1'b0;
        data_delay = 10;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        #1;
        while (!(mem_req && mem_we) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("reach_store", 32'(mem_we), 32'd1);
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        check_val("store_waiting", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("async_req", 32'(mem_req), 32'd0);
        check_val("async_we", 32'(mem_we), 32'd0);
        check_val("async_pc", pc, 32'h100);

        // Illegal opcode at the reset vector
        mem[12'h040] = 32'hFC00_0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rerun_req0", 32'(mem_req), 32'd0);
        @(negedge clk);
        #1;
        check_val("refetch_req", 32'(mem_req), 32'd1);
        check_val("refetch_addr", 32'(mem_addr), 32'h40);
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        check_val("trap_halted", 32'(halted), 32'd1);
        check_val("trap_req", 32'(mem_req), 32'd0);
        check_val("trap_pc", pc, 32'h104);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (mem_req || retire || !halted) bad++;
        end
        check_val("trap_stays", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
